// File: rtl/ddr_stub_responder.sv
// Memory-backed responder for the DDR streaming command interface. It accepts write bursts into a RAM and returns read bursts after RD_LATENCY.
// Optional protocol checker: define DDR_STUB_PROT_CHK_EN to add the sticky prot_err output.
module ddr_stub_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wstart,
  output logic                  wready,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [LEN_WIDTH-1:0]  wdata_len,
  input  logic                  wdata_vld,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rstart,
  output logic                  rready,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [LEN_WIDTH-1:0]  rdata_len,
  output logic                  rdata_vld,
`ifdef DDR_STUB_PROT_CHK_EN
  output logic                  prot_err,
`endif
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFS   = $clog2(BYTES);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = LEN_WIDTH + 1;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef logic [CW-1:0]         cnt_t;

  typedef enum logic {W_IDLE, W_DATA}  w_state_e;
  typedef enum logic {R_IDLE, R_ISSUE} r_state_e;

  function automatic cnt_t beats(input logic [LEN_WIDTH-1:0] len);
    return (cnt_t'(len) + cnt_t'(BYTES - 1)) >> OFS;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e w_state_q, w_state_d;
  idx_t     w_idx_q, w_idx_d;
  cnt_t     w_cnt_q, w_cnt_d;
  logic     wready_q;
  logic     w_we;

  r_state_e r_state_q, r_state_d;
  idx_t     r_idx_q, r_idx_d;
  cnt_t     r_cnt_q, r_cnt_d;
  logic     rready_q;
  logic     r_issue;

  logic [RD_LATENCY-2:0] vld_pipe_q;
  logic [RD_LATENCY-2:0] early_v;
  logic [DATA_WIDTH-1:0] data_pipe_q [RD_LATENCY-1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr, raddr};

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (wstart && wready_q && (wdata_len != '0)) begin
          w_idx_d   = waddr[OFS +: DEPTH_LOG2];
          w_cnt_d   = beats(wdata_len);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wdata_vld) begin
          w_we    = 1'b1;
          w_idx_d = w_idx_q + idx_t'(1);
          w_cnt_d = w_cnt_q - cnt_t'(1);
          if (w_cnt_q == cnt_t'(1)) w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      wready_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      wready_q  <= (w_state_d == W_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) mem[w_idx_q] <= wdata;
  end

  // The read engine stays busy until the last beat reaches the output stage, so rready rises the cycle after it.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    r_issue   = 1'b0;
    early_v   = vld_pipe_q;
    early_v[RD_LATENCY-2] = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rstart && rready_q && (rdata_len != '0)) begin
          r_idx_d   = raddr[OFS +: DEPTH_LOG2];
          r_cnt_d   = beats(rdata_len);
          r_state_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (r_cnt_q != '0) begin
          r_issue = 1'b1;
          r_idx_d = r_idx_q + idx_t'(1);
          r_cnt_d = r_cnt_q - cnt_t'(1);
        end else if (!(|early_v)) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      rready_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      rready_q  <= (r_state_d == R_IDLE);
    end
  end

  // Stage 0 is the RAM read register; later stages pad the latency out to RD_LATENCY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      data_pipe_q <= '{default: '0};
    end else begin
      vld_pipe_q[0]  <= r_issue;
      data_pipe_q[0] <= mem[r_idx_q];
      for (int unsigned i = 1; i < RD_LATENCY - 1; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        data_pipe_q[i] <= data_pipe_q[i-1];
      end
    end
  end

  assign wready    = wready_q;
  assign rready    = rready_q;
  assign rdata_vld = vld_pipe_q[RD_LATENCY-2];
  assign rdata     = data_pipe_q[RD_LATENCY-2];

`ifdef DDR_STUB_PROT_CHK_EN
  logic prot_err_q;
  logic viol;

  always_comb begin
    viol = (wdata_vld && (w_state_q == W_IDLE)) ||
           (wstart && !wready_q) || (rstart && !rready_q) ||
           (wstart && (wdata_len == '0)) || (rstart && (rdata_len == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prot_err_q <= 1'b0;
    else     prot_err_q <= prot_err_q | viol;
  end

  assign prot_err = prot_err_q;

`ifndef SYNTHESIS
  int unsigned sim_cyc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sim_cyc_q <= 0;
    end else begin
      sim_cyc_q <= sim_cyc_q + 1;
      if (viol) $display("ddr_stub_responder: protocol violation at cycle %0d", sim_cyc_q);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_ddr_stub_responder.sv
// Scoreboard bench for ddr_stub_responder: word-array reference model, randomized bursts, decoupled read-data monitor.
module tb_ddr_stub_responder;
  localparam int unsigned RDL = 2;
  localparam int unsigned D   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wstart, wready, wdata_vld, rstart, rready, rdata_vld;
  logic [31:0] waddr, raddr;
  logic [15:0] wdata_len, rdata_len;
  logic [63:0] wdata, rdata;
`ifdef DDR_STUB_PROT_CHK_EN
  logic        prot_err;
`endif

  ddr_stub_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .LEN_WIDTH(16), .DEPTH_LOG2(5), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rst(rst),
    .wstart(wstart), .wready(wready), .waddr(waddr), .wdata_len(wdata_len),
    .wdata_vld(wdata_vld), .wdata(wdata),
    .rstart(rstart), .rready(rready), .raddr(raddr), .rdata_len(rdata_len),
    .rdata_vld(rdata_vld),
`ifdef DDR_STUB_PROT_CHK_EN
    .prot_err(prot_err),
`endif
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int unsigned cyc;
  } exp_t;

  logic [63:0] model [D];
  exp_t        exp_q [$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rdata_vld) begin
      if (exp_q.size() == 0) begin
        chk1("unexpected_vld", rdata_vld, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", rdata, e.data);
        chk("rdata_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_wready();
    int unsigned n = 0;
    while (!wready && n < 200) begin @(negedge clk); n++; end
    chk1("wready_wait", wready, 1'b1);
  endtask

  task automatic wait_rready();
    int unsigned n = 0;
    while (!rready && n < 10000) begin @(negedge clk); n++; end
    chk1("rready_wait", rready, 1'b1);
  endtask

  task automatic push_read(input logic [31:0] addr, input int unsigned n, input int unsigned acc);
    int unsigned idx = (addr / 8) % D;
    for (int unsigned k = 0; k < n; k++)
      exp_q.push_back('{data: model[(idx + k) % D], cyc: acc + RDL - 1 + k});
  endtask

  task automatic finish_read(input int unsigned acc, input int unsigned n);
    int unsigned w = 0;
    while (!rready && w < n + RDL + 20) begin @(negedge clk); w++; end
    chk1("rready_return", rready, 1'b1);
    chk("rready_rise_cycle", 64'(cyc), 64'(acc + RDL + n - 1));
  endtask

  task automatic do_write(input logic [31:0] addr, input int unsigned len, input bit gaps,
                          input bit seq, input bit busy_start);
    int unsigned n   = (len + 7) / 8;
    int unsigned idx = (addr / 8) % D;
    logic [63:0] d;
    wait_wready();
    wstart = 1'b1; waddr = addr; wdata_len = 16'(len);
    @(negedge clk);
    wstart = 1'b0;
    if (n == 0) begin
      chk1("wready_zero_len", wready, 1'b1);
      return;
    end
    chk1("wready_busy", wready, 1'b0);
    for (int unsigned k = 0; k < n; k++) begin
      if (gaps) begin
        int unsigned g = $urandom_range(0, 2);
        repeat (g) begin wdata_vld = 1'b0; wstart = 1'b0; @(negedge clk); end
      end
      d = seq ? 64'(k) : {$urandom(), $urandom()};
      wstart    = busy_start && (k == 1);
      waddr     = 32'h3F8;
      wdata_len = 16'd8;
      wdata_vld = 1'b1;
      wdata     = d;
      model[(idx + k) % D] = d;
      @(negedge clk);
    end
    wdata_vld = 1'b0;
    wstart    = 1'b0;
    chk1("wready_after_last", wready, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int unsigned len);
    int unsigned n = (len + 7) / 8;
    int unsigned acc;
    wait_rready();
    rstart = 1'b1; raddr = addr; rdata_len = 16'(len);
    acc = cyc + 1;
    push_read(addr, n, acc);
    @(negedge clk);
    rstart = 1'b0;
    if (n == 0) begin
      chk1("rready_zero_len", rready, 1'b1);
      return;
    end
    chk1("rready_busy", rready, 1'b0);
    finish_read(acc, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    logic [63:0] d;
    rst = 1'b1;
    wstart = 1'b0; waddr = '0; wdata_len = '0; wdata_vld = 1'b0; wdata = '0;
    rstart = 1'b0; raddr = '0; rdata_len = '0;
    @(negedge clk); @(negedge clk);
    chk1("reset_wready", wready, 1'b0);
    chk1("reset_rready", rready, 1'b0);
    chk1("reset_rdata_vld", rdata_vld, 1'b0);
    chk("reset_rdata", rdata, 64'h0);
`ifdef DDR_STUB_PROT_CHK_EN
    chk1("reset_prot_err", prot_err, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk1("wready_after_reset", wready, 1'b1);
    chk1("rready_after_reset", rready, 1'b1);

    // known contents everywhere
    do_write(32'h0, 256, 1'b0, 1'b0, 1'b0);

    do_write(32'h0, 64, 1'b0, 1'b1, 1'b0);
    do_read(32'h0, 64);

    do_write(32'h13, 9, 1'b0, 1'b0, 1'b0);
    do_read(32'h10, 16);

    do_write(32'hF0, 32, 1'b0, 1'b0, 1'b0);
    do_read(32'h0, 16);
    do_read(32'hF0, 32);

    // concurrent 16-beat write (words 0..15) and read (words 16..31)
    wait_wready();
    wait_rready();
    wstart = 1'b1; waddr = 32'h0;  wdata_len = 16'd128;
    rstart = 1'b1; raddr = 32'h80; rdata_len = 16'd128;
    acc = cyc + 1;
    push_read(32'h80, 16, acc);
    @(negedge clk);
    wstart = 1'b0; rstart = 1'b0;
    chk1("conc_wready_busy", wready, 1'b0);
    chk1("conc_rready_busy", rready, 1'b0);
    for (int unsigned k = 0; k < 16; k++) begin
      d = {$urandom(), $urandom()};
      wdata_vld = 1'b1; wdata = d; model[k] = d;
      @(negedge clk);
    end
    wdata_vld = 1'b0;
    chk1("conc_wready_done", wready, 1'b1);
    finish_read(acc, 16);
    do_read(32'h0, 128);

    // illegal requests
    do_write(32'h20, 0, 1'b0, 1'b0, 1'b0);
    do_read(32'h20, 0);
    for (int unsigned k = 0; k < 3; k++) begin
      wdata_vld = 1'b1; wdata = {$urandom(), $urandom()};
      @(negedge clk);
      chk1("stray_vld_wready", wready, 1'b1);
    end
    wdata_vld = 1'b0;
    do_write(32'h48, 40, 1'b1, 1'b0, 1'b1);
    do_read(32'h0, 256);
`ifdef DDR_STUB_PROT_CHK_EN
    chk1("prot_err_set", prot_err, 1'b1);
`endif

    for (int unsigned it = 0; it < 20; it++) begin
      do_write($urandom_range(0, 1023), $urandom_range(1, 300), ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
      do_read($urandom_range(0, 1023), $urandom_range(1, 300));
    end

    // longest legal length: 8192 beats through the widened counter
    do_read(32'h8, 16'hFFFF);

    // reset during the third beat of an 8-beat read
    do_write(32'h40, 64, 1'b0, 1'b0, 1'b0);
    wait_rready();
    rstart = 1'b1; raddr = 32'h40; rdata_len = 16'd64;
    acc = cyc + 1;
    push_read(32'h40, 8, acc);
    @(negedge clk);
    rstart = 1'b0;
    while (cyc < acc + RDL + 1) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("vld_dropped_on_rst", rdata_vld, 1'b0);
    chk1("rready_in_rst", rready, 1'b0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rready_after_rst_release", rready, 1'b1);
    chk1("wready_after_rst_release", wready, 1'b1);
    do_read(32'h40, 64);

    for (int unsigned w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
